// File: rtl/i2s_sample_tx.sv
// i2s_sample_tx: buffers mixed mono audio samples in a small FIFO and sends each
// one as a stereo I2S frame, the same sample in the left and the right slot.
// The serial word goes through a one-slot delay flop, so every word's MSB
// appears one bit clock after the lrck edge.
module i2s_sample_tx #(
    parameter int SAMPLE_W   = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int SCLK_DIV   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [SAMPLE_W-1:0]           sample_in,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    output logic                          sclk,
    output logic                          lrck,
    output logic                          sdata
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int FW = 2 * SAMPLE_W;
    localparam int SW = $clog2(FW);
    localparam logic [DW-1:0] DIV_LAST   = DW'(SCLK_DIV - 1);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(FW - 1);
    localparam logic [SW-1:0] LEFT_LAST  = SW'(SAMPLE_W - 1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t              state;
    logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [DW-1:0]       div_cnt;
    logic [SW-1:0]       slot_cnt;
    logic [FW-1:0]       shift_word;
    logic [SAMPLE_W-1:0] head;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic                load;
    logic                slot_end;
    logic                frame_end;

    assign sample_ready = (fifo_level != LEVEL_FULL);
    assign fifo_empty   = (fifo_level == '0);
    assign push         = sample_valid && sample_ready;
    assign head         = mem[rd_ptr];

    // A slot ends on the last clk of its sclk-high half; the next edge starts a new slot.
    assign slot_end  = (state == ST_RUN) && sclk && (div_cnt == DIV_LAST);
    assign frame_end = slot_end && (slot_cnt == SLOT_LAST);

    // The frame word is loaded on the edge that enters slot 0 (start of RUN or frame wrap).
    assign load = enable && ((state == ST_IDLE) || frame_end);
    assign pop  = load && !fifo_empty;

    // FIFO storage: written on accepted pushes only.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sample_in;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves the level unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                fifo_level <= fifo_level + LW'(1);
            end else if (pop && !push) begin
                fifo_level <= fifo_level - LW'(1);
            end
        end
    end

    // Frame shift word: {S,S} on load (zero on underrun), MSB out at every slot end.
    always_ff @(posedge clk) begin
        if (load) begin
            shift_word <= pop ? {head, head} : '0;
        end else if (slot_end) begin
            shift_word <= {shift_word[FW-2:0], 1'b0};
        end
    end

    // Run/idle FSM with bit-clock divider, slot counter, lrck, delayed sdata and underrun pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            div_cnt  <= '0;
            slot_cnt <= '0;
            sclk     <= 1'b0;
            lrck     <= 1'b0;
            sdata    <= 1'b0;
            underrun <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (state == ST_IDLE || !enable) begin
                // Idle or abort: everything serial returns to zero, the next run starts at slot 0.
                div_cnt  <= '0;
                slot_cnt <= '0;
                sclk     <= 1'b0;
                lrck     <= 1'b0;
                sdata    <= 1'b0;
                if (state == ST_IDLE && enable) begin
                    state    <= ST_RUN;
                    underrun <= fifo_empty;
                end else begin
                    state <= ST_IDLE;
                end
            end else begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt <= '0;
                    sclk    <= ~sclk;
                end else begin
                    div_cnt <= div_cnt + DW'(1);
                end
                if (slot_end) begin
                    sdata <= shift_word[FW-1];
                    if (slot_cnt == SLOT_LAST) begin
                        slot_cnt <= '0;
                        lrck     <= 1'b0;
                        underrun <= fifo_empty;
                    end else begin
                        slot_cnt <= slot_cnt + SW'(1);
                        lrck     <= (slot_cnt >= LEFT_LAST);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_sample_tx.sv
// tb_i2s_sample_tx: directed bench for the I2S sample transmitter.
module tb_i2s_sample_tx;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        sample_ready;
    logic [2:0]  fifo_level;
    logic        underrun;
    logic        sclk;
    logic        lrck;
    logic        sdata;

    int n_cmp;
    int n_err;

    i2s_sample_tx #(
        .SAMPLE_W   (16),
        .FIFO_DEPTH (4),
        .SCLK_DIV   (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .fifo_level   (fifo_level),
        .underrun     (underrun),
        .sclk         (sclk),
        .lrck         (lrck),
        .sdata        (sdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called in the first clk of slot 0; walks one 256-clk frame and ends in the next slot 0.
    task automatic run_frame(input string tag, input logic [15:0] s, input logic prev,
                             input logic exp_ur);
        logic [31:0] cap_d;
        logic [31:0] cap_l0;
        logic [31:0] cap_l4;
        logic [31:0] exp_d;
        logic        s0;
        logic        sclk_bad;
        logic        stab_bad;
        logic        ur_first;
        int          ur_cnt;
        int          k;
        int          o;
        cap_d    = '0;
        cap_l0   = '0;
        cap_l4   = '0;
        s0       = 1'b0;
        sclk_bad = 1'b0;
        stab_bad = 1'b0;
        ur_first = 1'b0;
        ur_cnt   = 0;
        for (int i = 0; i < 256; i++) begin
            k = i / 8;
            o = i % 8;
            if (sclk !== (o >= 4)) sclk_bad = 1'b1;
            if (o == 0) begin
                s0 = sdata;
                cap_l0[31-k] = lrck;
            end else if (sdata !== s0) begin
                stab_bad = 1'b1;
            end
            if (o == 4) begin
                cap_d[31-k]  = sdata;
                cap_l4[31-k] = lrck;
            end
            if (underrun === 1'b1) ur_cnt++;
            if (i == 0) ur_first = underrun;
            tick();
        end
        exp_d = {prev, s, s[15:1]};
        check({tag, "_sdata"}, cap_d, exp_d);
        check({tag, "_lrck_low_half"}, cap_l0, 32'h0000FFFF);
        check({tag, "_lrck_high_half"}, cap_l4, 32'h0000FFFF);
        check({tag, "_sclk_shape"}, {31'd0, sclk_bad}, 32'd0);
        check({tag, "_sdata_stable"}, {31'd0, stab_bad}, 32'd0);
        check({tag, "_underrun_count"}, ur_cnt, {31'd0, exp_ur});
        check({tag, "_underrun_slot0"}, {31'd0, ur_first}, {31'd0, exp_ur});
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        enable       = 1'b0;
        sample_in    = '0;
        sample_valid = 1'b0;

        // reset state
        tick();
        tick();
        check("rst_sclk", {31'd0, sclk}, 32'd0);
        check("rst_lrck", {31'd0, lrck}, 32'd0);
        check("rst_sdata", {31'd0, sdata}, 32'd0);
        check("rst_level", {29'd0, fifo_level}, 32'd0);
        check("rst_ready", {31'd0, sample_ready}, 32'd1);
        check("rst_underrun", {31'd0, underrun}, 32'd0);
        rst_n = 1'b1;
        tick();

        // T2 single frame of 16'hA5F0
        sample_in    = 16'hA5F0;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        check("t2_level_push", {29'd0, fifo_level}, 32'd1);
        enable = 1'b1;
        tick();
        check("t2_level_load", {29'd0, fifo_level}, 32'd0);
        run_frame("t2", 16'hA5F0, 1'b0, 1'b0);
        check("t2_next_slot0", {31'd0, sdata}, 32'd0);
        enable = 1'b0;
        tick();
        check("idle_sclk", {31'd0, sclk}, 32'd0);
        check("idle_sdata", {31'd0, sdata}, 32'd0);

        // T3 underrun for three frames
        enable = 1'b1;
        tick();
        run_frame("t3_f0", 16'h0000, 1'b0, 1'b1);
        run_frame("t3_f1", 16'h0000, 1'b0, 1'b1);
        run_frame("t3_f2", 16'h0000, 1'b0, 1'b1);
        enable = 1'b0;
        tick();

        // T4 fill and backpressure, then drain in order
        sample_valid = 1'b1;
        sample_in = 16'd10000; tick();
        sample_in = 16'd0;     tick();
        sample_in = 16'd500;   tick();
        sample_in = 16'd10;    tick();
        check("t4_level_full", {29'd0, fifo_level}, 32'd4);
        check("t4_ready_full", {31'd0, sample_ready}, 32'd0);
        sample_in = 16'd1;     tick();
        check("t4_level_reject", {29'd0, fifo_level}, 32'd4);
        sample_valid = 1'b0;
        enable = 1'b1;
        tick();
        check("t4_ready_back", {31'd0, sample_ready}, 32'd1);
        check("t4_level_3", {29'd0, fifo_level}, 32'd3);
        run_frame("t4_f0", 16'd10000, 1'b0, 1'b0);
        check("t4_level_2", {29'd0, fifo_level}, 32'd2);
        run_frame("t4_f1", 16'd0, 1'b0, 1'b0);
        run_frame("t4_f2", 16'd500, 1'b0, 1'b0);
        run_frame("t4_f3", 16'd10, 1'b0, 1'b0);
        check("t4_level_0", {29'd0, fifo_level}, 32'd0);
        check("t4_underrun_after", {31'd0, underrun}, 32'd1);
        enable = 1'b0;
        tick();

        // T6 push coincident with frame load at level 2
        sample_valid = 1'b1;
        sample_in = 16'h1234; tick();
        sample_in = 16'h8001; tick();
        check("t6_level_2", {29'd0, fifo_level}, 32'd2);
        sample_in = 16'h7FFE;
        enable    = 1'b1;
        tick();
        sample_valid = 1'b0;
        check("t6_level_same", {29'd0, fifo_level}, 32'd2);
        run_frame("t6_f0", 16'h1234, 1'b0, 1'b0);
        run_frame("t6_f1", 16'h8001, 1'b0, 1'b0);
        run_frame("t6_f2", 16'h7FFE, 1'b1, 1'b0);
        check("t6_tail_bit", {31'd0, sdata}, 32'd0);
        check("t6_level_end", {29'd0, fifo_level}, 32'd0);
        enable = 1'b0;
        tick();

        // T5 enable drop in the left slot of 16'hFFFF
        sample_valid = 1'b1;
        sample_in = 16'hFFFF; tick();
        sample_in = 16'h0F0F; tick();
        sample_valid = 1'b0;
        enable = 1'b1;
        tick();
        repeat (42) tick();
        check("t5_mid_sdata", {31'd0, sdata}, 32'd1);
        check("t5_mid_lrck", {31'd0, lrck}, 32'd0);
        enable = 1'b0;
        tick();
        check("t5_abort_sclk", {31'd0, sclk}, 32'd0);
        check("t5_abort_lrck", {31'd0, lrck}, 32'd0);
        check("t5_abort_sdata", {31'd0, sdata}, 32'd0);
        check("t5_abort_level", {29'd0, fifo_level}, 32'd1);
        enable = 1'b1;
        tick();
        run_frame("t5_f0", 16'h0F0F, 1'b0, 1'b0);
        check("t5_tail_bit", {31'd0, sdata}, 32'd1);
        check("t5_tail_underrun", {31'd0, underrun}, 32'd1);

        // T1 asynchronous reset in the middle of a frame
        sample_valid = 1'b1;
        sample_in    = 16'h4321;
        tick();
        sample_valid = 1'b0;
        repeat (4) tick();
        check("t1_pre_sclk", {31'd0, sclk}, 32'd1);
        check("t1_pre_sdata", {31'd0, sdata}, 32'd1);
        check("t1_pre_level", {29'd0, fifo_level}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_async_sclk", {31'd0, sclk}, 32'd0);
        check("t1_async_lrck", {31'd0, lrck}, 32'd0);
        check("t1_async_sdata", {31'd0, sdata}, 32'd0);
        check("t1_async_level", {29'd0, fifo_level}, 32'd0);
        check("t1_async_ready", {31'd0, sample_ready}, 32'd1);
        rst_n = 1'b1;
        tick();
        run_frame("t1_restart", 16'h0000, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
